// File: rtl/serial_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encodings and the
// default operand width used by the board build.
package serial_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int DEFAULT_WIDTH = 4;

endpackage : serial_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: D = A - B - Bin, with borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single
// full-subtractor cell, with a start/ready/done handshake.
module serial_subtractor
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  // The last difference bit goes straight into diff, so sd only ever
  // needs to hold the WIDTH-1 bits produced before it.
  logic [WIDTH-2:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             dBit;
  logic             brNext;
  logic [WIDTH-1:0] shifted;

  full_subtractor u_fullSub (
    .A    (ra_q[0]),
    .B    (rb_q[0]),
    .Bin  (br_q),
    .D    (dBit),
    .Bout (brNext)
  );

  assign shifted = {dBit, sd_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    sd_d     = sd_q;
    br_d     = br_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          cnt_d   = '0;
          br_d    = 1'b0;
          sd_d    = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sd_d  = shifted[WIDTH-1:1];
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        br_d  = brNext;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d   = shifted;
          borrow_d = brNext;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      sd_q     <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      sd_q     <= sd_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor against an
// arithmetic reference: diff = (a - b) mod 16, borrow = (a < b).
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, borrow;
  logic [W-1:0] diff;

  int checks = 0;
  int failures = 0;
  int expDiff = 0;
  int expBorrow = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference result computed with plain integer arithmetic.
  task automatic model(input int av, input int bv);
    expDiff   = (av - bv) & ((1 << W) - 1);
    expBorrow = (av < bv) ? 1 : 0;
  endtask

  // Launches one operation from IDLE, then checks latency, results and return to IDLE.
  task automatic applyStimulus(input int av, input int bv);
    int lat;
    int prevDiff;
    int prevBorrow;
    prevDiff   = expDiff;
    prevBorrow = expBorrow;
    a     = W'(av);
    b     = W'(bv);
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = ~a;
    b     = ~b;
    checkOutput("busy_after_accept", {31'b0, busy}, 1);
    checkOutput("ready_after_accept", {31'b0, ready}, 0);
    checkOutput("diff_held_in_flight", {28'b0, diff}, prevDiff);
    checkOutput("borrow_held_in_flight", {31'b0, borrow}, prevBorrow);
    model(av, bv);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      if (done !== 1'b1) checkOutput("busy_ready_exclusive", {31'b0, busy & ready}, 0);
    end
    checkOutput("done_latency", lat, W);
    checkOutput("done_not_busy", {31'b0, busy}, 0);
    checkOutput("diff", {28'b0, diff}, expDiff);
    checkOutput("borrow", {31'b0, borrow}, expBorrow);
    tick();
    checkOutput("done_one_cycle", {31'b0, done}, 0);
    checkOutput("ready_returns", {31'b0, ready}, 1);
    checkOutput("diff_holds", {28'b0, diff}, expDiff);
  endtask

  initial begin
    int lastDone;
    int doneCount;
    int sawDone;

    $display("[TB] reset");
    rst_n = 1'b0;
    tick();
    tick();
    checkOutput("reset_ready", {31'b0, ready}, 1);
    checkOutput("reset_busy", {31'b0, busy}, 0);
    checkOutput("reset_done", {31'b0, done}, 0);
    checkOutput("reset_diff", {28'b0, diff}, 0);
    checkOutput("reset_borrow", {31'b0, borrow}, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] directed operands");
    applyStimulus(9, 3);
    checkOutput("dir_9_3_diff", {28'b0, diff}, 6);
    applyStimulus(3, 9);
    checkOutput("dir_3_9_diff", {28'b0, diff}, 10);
    checkOutput("dir_3_9_borrow", {31'b0, borrow}, 1);
    applyStimulus(0, 1);
    checkOutput("dir_0_1_diff", {28'b0, diff}, 15);
    applyStimulus(15, 15);
    checkOutput("dir_15_15_borrow", {31'b0, borrow}, 0);

    $display("[TB] start while busy is ignored");
    a = 4'd9; b = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'd1; b = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("ignored_done", {31'b0, done}, 1);
    checkOutput("ignored_diff", {28'b0, diff}, 6);
    checkOutput("ignored_borrow", {31'b0, borrow}, 0);
    checkOutput("ignored_ready_in_done", {31'b0, ready}, 0);
    tick();
    checkOutput("ignored_ready_e5", {31'b0, ready}, 1);
    expDiff = 6; expBorrow = 0;

    $display("[TB] reset mid-operation");
    a = 4'd9; b = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midrst_ready", {31'b0, ready}, 1);
    checkOutput("midrst_busy", {31'b0, busy}, 0);
    checkOutput("midrst_diff", {28'b0, diff}, 0);
    checkOutput("midrst_borrow", {31'b0, borrow}, 0);
    sawDone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) sawDone = 1;
    end
    checkOutput("midrst_no_done", sawDone, 0);
    expDiff = 0; expBorrow = 0;
    applyStimulus(7, 2);

    $display("[TB] back-to-back with start held");
    a = 4'd12; b = 4'd5; start = 1'b1;
    lastDone = -1;
    doneCount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) begin
        doneCount++;
        checkOutput("b2b_diff", {28'b0, diff}, 7);
        if (lastDone >= 0) checkOutput("b2b_spacing", i - lastDone, W + 2);
        lastDone = i;
      end
    end
    start = 1'b0;
    checkOutput("b2b_done_count", doneCount, 3);
    for (int i = 0; i < 8 && ready !== 1'b1; i++) tick();
    checkOutput("b2b_back_to_idle", {31'b0, ready}, 1);
    expDiff = 7; expBorrow = 0;

    $display("[TB] exhaustive sweep");
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        applyStimulus(x, y);

    $display("[TB] random operands");
    for (int k = 0; k < 40; k++)
      applyStimulus(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_subtractor
